// File: rtl/riscv_trace_pkg.sv
// rtl/riscv_trace_pkg.sv - shared types and constants for the riscv commit/memory trace buffer
package riscv_trace_pkg;

    // Bit positions of the event classes inside a kind vector and ev_mask
    localparam int KIND_REG_WR = 0;
    localparam int KIND_MEM_WR = 1;
    localparam int KIND_MEM_RD = 2;

    // Width of the saturating overflow counter
    localparam int OVF_W = 16;

    // Default field widths of a trace entry
    localparam int TRACE_TS_W   = 16;
    localparam int TRACE_REG_W  = 5;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_ADDR_W = 9;

    // Event class flags, reg_wr in bit 0
    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
    } trace_kind_t;

    // One captured entry at the default widths; the top builds the same layout from its own parameters
    typedef struct packed {
        logic [TRACE_TS_W-1:0]   ts;
        trace_kind_t             kind;
        logic [TRACE_REG_W-1:0]  reg_num;
        logic [TRACE_DATA_W-1:0] reg_data;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] mem_data;
    } trace_entry_t;

endpackage

// File: rtl/trace_ring.sv
// rtl/trace_ring.sv - circular entry store with drop-or-overwrite handling when full
module trace_ring #(
    parameter int  DEPTH     = 16,
    parameter bit  WRAP_MODE = 1'b0,
    parameter type entry_t   = logic [7:0],
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             ovf_evt
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;
    logic             blocked;
    logic             accept;
    logic             overwrite;

    // Decide accept/drop/overwrite for this cycle and compute the next pointers and count
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready && !clear;
        blocked   = push && !clear && full && !pop;
        accept    = push && !clear && (!blocked || WRAP_MODE);
        overwrite = blocked && WRAP_MODE;
        ovf_evt   = blocked;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (accept && !pop && !overwrite) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !accept) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        head  = mem_q[rd_ptr_q];
        count = count_q;
    end

    // Pointer and occupancy registers; reset empties the ring so stale storage is never visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the slot under the write pointer
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/riscv_trace_buffer.sv
// rtl/riscv_trace_buffer.sv - timestamped register-writeback and data-memory trace capture
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int TS_W      = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [2:0]               ev_mask,
    input  logic                     reg_write_sig,
    input  logic [REG_W-1:0]         reg_num,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     halt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [2:0]               out_kind,
    output logic [REG_W-1:0]         out_reg_num,
    output logic [DATA_W-1:0]        out_reg_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_mem_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [OVF_W-1:0]         overflow_cnt,
    output logic                     stopped,
    output logic                     err_conflict
);

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        trace_kind_t       kind;
        logic [REG_W-1:0]  reg_num;
        logic [DATA_W-1:0] reg_data;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] mem_data;
    } entry_t;

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             stopped_q, stopped_d;
    logic             err_q, err_d;
    trace_kind_t      kind;
    entry_t           entry;
    entry_t           head;
    logic             push;
    logic             ring_valid;
    logic             ovf_evt;

    // Qualify events, build the entry with absent fields zeroed, and update sticky state
    always_comb begin
        kind.reg_wr = ev_mask[KIND_REG_WR] && reg_write_sig && (reg_num != '0);
        kind.mem_wr = ev_mask[KIND_MEM_WR] && wr && !rd;
        kind.mem_rd = ev_mask[KIND_MEM_RD] && rd && !wr;

        entry.ts       = ts_q;
        entry.kind     = kind;
        entry.reg_num  = kind.reg_wr ? reg_num : '0;
        entry.reg_data = kind.reg_wr ? reg_data : '0;
        entry.addr     = (kind.mem_wr || kind.mem_rd) ? addr : '0;
        entry.mem_data = kind.mem_wr ? wr_data : (kind.mem_rd ? rd_data : '0);

        push = enable && !stopped_q && !clear && (kind != '0);

        ts_d      = ts_q + TS_W'(1);
        ovf_d     = ovf_q;
        stopped_d = stopped_q;
        err_d     = err_q || (wr && rd);
        if (ovf_evt && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
        if (halt && enable) begin
            stopped_d = 1'b1;
        end
        if (clear) begin
            ts_d      = '0;
            ovf_d     = '0;
            stopped_d = 1'b0;
            err_d     = 1'b0;
        end
    end

    // Timestamp, overflow counter and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q      <= '0;
            ovf_q     <= '0;
            stopped_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ts_q      <= ts_d;
            ovf_q     <= ovf_d;
            stopped_q <= stopped_d;
            err_q     <= err_d;
        end
    end

    trace_ring #(
        .DEPTH    (DEPTH),
        .WRAP_MODE(WRAP_MODE != 0),
        .entry_t  (entry_t)
    ) u_ring (
        .clk      (clk),
        .rst      (reset),
        .clear    (clear),
        .push     (push),
        .push_data(entry),
        .out_ready(out_ready),
        .out_valid(ring_valid),
        .head     (head),
        .count    (count),
        .full     (full),
        .ovf_evt  (ovf_evt)
    );

    // Present the head entry, forced to zero while the buffer is empty so storage never leaks out
    always_comb begin
        out_valid    = ring_valid;
        out_ts       = ring_valid ? head.ts : '0;
        out_kind     = ring_valid ? head.kind : '0;
        out_reg_num  = ring_valid ? head.reg_num : '0;
        out_reg_data = ring_valid ? head.reg_data : '0;
        out_addr     = ring_valid ? head.addr : '0;
        out_mem_data = ring_valid ? head.mem_data : '0;
        overflow_cnt = ovf_q;
        stopped      = stopped_q;
        err_conflict = err_q;
    end

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb/tb_riscv_trace_buffer.sv - directed self-checking bench for riscv_trace_buffer
module tb_riscv_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [2:0]  ev_mask;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        halt;
    logic        out_ready;

    logic        v0, v1;
    logic [15:0] ts0, ts1;
    logic [2:0]  k0, k1;
    logic [4:0]  rn0, rn1;
    logic [31:0] rdat0, rdat1;
    logic [8:0]  a0, a1;
    logic [31:0] md0, md1;
    logic [2:0]  c0, c1;
    logic        f0, f1;
    logic [15:0] ov0, ov1;
    logic        s0, s1;
    logic        e0, e1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .ev_mask(ev_mask),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .halt(halt),
        .out_valid(v0), .out_ready(out_ready), .out_ts(ts0), .out_kind(k0),
        .out_reg_num(rn0), .out_reg_data(rdat0), .out_addr(a0), .out_mem_data(md0),
        .count(c0), .full(f0), .overflow_cnt(ov0), .stopped(s0), .err_conflict(e0)
    );

    riscv_trace_buffer #(.DEPTH(4), .WRAP_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .ev_mask(ev_mask),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .halt(halt),
        .out_valid(v1), .out_ready(out_ready), .out_ts(ts1), .out_kind(k1),
        .out_reg_num(rn1), .out_reg_data(rdat1), .out_addr(a1), .out_mem_data(md1),
        .count(c1), .full(f1), .overflow_cnt(ov1), .stopped(s1), .err_conflict(e1)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  rn;
        logic [31:0] rdv;
        logic        w;
        logic        r;
        logic [8:0]  ad;
        logic [31:0] wd;
        logic [31:0] ld;
        logic [2:0]  mask;
        logic        e_push;
        logic [2:0]  e_kind;
        logic [4:0]  e_rn;
        logic [31:0] e_rdv;
        logic [8:0]  e_ad;
        logic [31:0] e_md;
        logic        e_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        enable        = 1'b1;
        clear         = 1'b0;
        ev_mask       = 3'b111;
        reg_write_sig = 1'b0;
        reg_num       = '0;
        reg_data      = '0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = '0;
        wr_data       = '0;
        rd_data       = '0;
        halt          = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic store(input logic [8:0] a);
        wr      = 1'b1;
        addr    = a;
        wr_data = 32'h100 + 32'(a);
        tick();
        wr      = 1'b0;
        addr    = '0;
        wr_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 5, 32'h2A, 0, 0, 9'h0, 0, 0, 3'b111, 1, 3'b001, 5, 32'h2A, 9'h0, 0, 0};
        vecs[1] = '{1, 0, 32'h77, 0, 0, 9'h0, 0, 0, 3'b111, 0, 3'b000, 0, 0, 9'h0, 0, 0};
        vecs[2] = '{0, 0, 0, 1, 1, 9'h10, 32'h5, 32'h6, 3'b111, 0, 3'b000, 0, 0, 9'h0, 0, 1};
        vecs[3] = '{0, 0, 0, 1, 0, 9'h10, 32'h1234, 32'h9, 3'b111, 1, 3'b010, 0, 0, 9'h10, 32'h1234, 0};
        vecs[4] = '{0, 0, 0, 0, 1, 9'h1F, 32'h9, 32'hDEAD, 3'b111, 1, 3'b100, 0, 0, 9'h1F, 32'hDEAD, 0};
        vecs[5] = '{1, 3, 32'h55, 1, 0, 9'h20, 32'h77, 32'h0, 3'b111, 1, 3'b011, 3, 32'h55, 9'h20, 32'h77, 0};
        vecs[6] = '{1, 7, 32'h9, 1, 1, 9'h30, 32'h1, 32'h2, 3'b111, 1, 3'b001, 7, 32'h9, 9'h0, 0, 1};
        vecs[7] = '{0, 0, 0, 1, 0, 9'h40, 32'h3, 32'h0, 3'b101, 0, 3'b000, 0, 0, 9'h0, 0, 0};
        vecs[8] = '{1, 4, 32'h8, 0, 1, 9'h05, 32'h0, 32'hBEEF, 3'b100, 1, 3'b100, 0, 0, 9'h05, 32'hBEEF, 0};
        vecs[9] = '{1, 31, 32'hFFFFFFFF, 0, 1, 9'h1FF, 32'h0, 32'h4, 3'b001, 1, 3'b001, 31, 32'hFFFFFFFF, 9'h0, 0, 0};

        idle();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(v0), 0);
        chk("rst_count", 64'(c0), 0);
        chk("rst_ovf", 64'(ov0), 0);
        chk("rst_stopped", 64'(s0), 0);
        chk("rst_err", 64'(e0), 0);
        chk("rst_ts", 64'(ts0), 0);
        reset = 1'b0;

        // Test 1: register write captured at ts=3, visible the following cycle
        tick();
        tick();
        tick();
        reg_write_sig = 1'b1;
        reg_num       = 5'd5;
        reg_data      = 32'h2A;
        chk("t1_latency", 64'(v0), 0);
        tick();
        idle();
        chk("t1_valid", 64'(v0), 1);
        chk("t1_ts", 64'(ts0), 3);
        chk("t1_kind", 64'(k0), 1);
        chk("t1_regnum", 64'(rn0), 5);
        chk("t1_regdata", 64'(rdat0), 32'h2A);
        chk("t1_count", 64'(c0), 1);

        // Table: single-cycle qualification patterns
        for (int i = 0; i < 10; i++) begin
            do_clear();
            ev_mask       = vecs[i].mask;
            reg_write_sig = vecs[i].rw;
            reg_num       = vecs[i].rn;
            reg_data      = vecs[i].rdv;
            wr            = vecs[i].w;
            rd            = vecs[i].r;
            addr          = vecs[i].ad;
            wr_data       = vecs[i].wd;
            rd_data       = vecs[i].ld;
            tick();
            idle();
            chk($sformatf("v%0d_count", i), 64'(c0), 64'(vecs[i].e_push));
            chk($sformatf("v%0d_err", i), 64'(e0), 64'(vecs[i].e_err));
            if (vecs[i].e_push) begin
                chk($sformatf("v%0d_kind", i), 64'(k0), 64'(vecs[i].e_kind));
                chk($sformatf("v%0d_regnum", i), 64'(rn0), 64'(vecs[i].e_rn));
                chk($sformatf("v%0d_regdata", i), 64'(rdat0), 64'(vecs[i].e_rdv));
                chk($sformatf("v%0d_addr", i), 64'(a0), 64'(vecs[i].e_ad));
                chk($sformatf("v%0d_memdata", i), 64'(md0), 64'(vecs[i].e_md));
                chk($sformatf("v%0d_ts", i), 64'(ts0), 0);
            end
        end

        // Tests 3/4: six stores into a depth-4 buffer, drop vs overwrite
        do_clear();
        for (int i = 1; i <= 6; i++) begin
            store(9'(i));
        end
        chk("t3_count", 64'(c0), 4);
        chk("t3_full", 64'(f0), 1);
        chk("t3_ovf", 64'(ov0), 2);
        chk("t4_count", 64'(c1), 4);
        chk("t4_ovf", 64'(ov1), 2);
        chk("t4_head_md", 64'(md1), 32'h103);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_drain%0d", i), 64'(a0), 64'(i + 1));
            chk($sformatf("t4_drain%0d", i), 64'(a1), 64'(i + 3));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_empty", 64'(c0), 0);
        chk("t4_empty", 64'(v1), 0);

        // Test 5: halt freezes capture after its own cycle, clear resumes
        do_clear();
        rd      = 1'b1;
        addr    = 9'h1F;
        rd_data = 32'hDEAD;
        halt    = 1'b1;
        tick();
        idle();
        chk("t5_stopped", 64'(s0), 1);
        reg_write_sig = 1'b1;
        reg_num       = 5'd9;
        reg_data      = 32'h11;
        tick();
        idle();
        chk("t5_count", 64'(c0), 1);
        chk("t5_kind", 64'(k0), 3'b100);
        chk("t5_memdata", 64'(md0), 32'hDEAD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_readout", 64'(c0), 0);
        chk("t5_still_stopped", 64'(s0), 1);
        do_clear();
        chk("t5_clr_stopped", 64'(s0), 0);
        chk("t5_clr_ovf", 64'(ov0), 0);
        reg_write_sig = 1'b1;
        reg_num       = 5'd2;
        reg_data      = 32'h22;
        tick();
        idle();
        chk("t5_resume", 64'(c0), 1);
        chk("t5_resume_ts", 64'(ts0), 0);

        // Test 6: full with simultaneous push and pop, then async reset mid-drain
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            store(9'(i));
        end
        chk("t6_full", 64'(f0), 1);
        out_ready = 1'b1;
        store(9'd9);
        out_ready = 1'b0;
        chk("t6_count0", 64'(c0), 4);
        chk("t6_ovf0", 64'(ov0), 0);
        chk("t6_head0", 64'(a0), 2);
        chk("t6_count1", 64'(c1), 4);
        chk("t6_ovf1", 64'(ov1), 0);
        chk("t6_head1", 64'(a1), 2);
        out_ready = 1'b1;
        tick();
        chk("t6_drain", 64'(c0), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid0", 64'(v0), 0);
        chk("t6_rst_valid1", 64'(v1), 0);
        chk("t6_rst_count", 64'(c0), 0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("t6_after_rst", 64'(v0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
